// File: rtl/misao_mem_ctrl_if.sv
// Core-side and external-bus signals of the memory controller.
// The controller attaches through the slave modport; the core/memory side uses master.
interface misao_mem_ctrl_if;
    logic        cpu_enable_read;
    logic        cpu_enable_write;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [14:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;
    logic        err_clr;
    logic        bus_err;

    modport slave (
        input  cpu_enable_read, cpu_enable_write, cpu_addr, cpu_wdata,
               ext_rdata, ext_ack, err_clr,
        output cpu_rdata, cpu_ready, cpu_stall,
               ext_req, ext_we, ext_addr, ext_wdata, bus_err
    );

    modport master (
        output cpu_enable_read, cpu_enable_write, cpu_addr, cpu_wdata,
               ext_rdata, ext_ack, err_clr,
        input  cpu_rdata, cpu_ready, cpu_stall,
               ext_req, ext_we, ext_addr, ext_wdata, bus_err
    );
endinterface

// File: rtl/misao_mem_ctrl.sv
// Single-port memory controller with a one-entry read buffer, write-through
// coherence for that entry, and a bounded wait for the external acknowledge.
module misao_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic               clk,
    input logic               rst,
    misao_mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        err_flag;
    logic        buf_valid;
    logic [14:0] buf_addr;
    logic [7:0]  buf_data;
    logic        ext_req;
    logic        ext_we;
    logic [14:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        bus_err;

    logic        read_only;
    logic        hit;
    logic        start;
    logic        timeout;

    // Write has priority, so a read is only a buffer lookup when write is low.
    assign read_only = bus.cpu_enable_read & ~bus.cpu_enable_write;
    assign hit       = (state == IDLE) & read_only & buf_valid & (bus.cpu_addr == buf_addr);
    assign start     = (state == IDLE) & (bus.cpu_enable_write | (bus.cpu_enable_read & ~hit));
    assign timeout   = (state == REQ) & ~bus.ext_ack & (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            err_flag  <= 1'b0;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                bus_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ext_req   <= 1'b1;
                        ext_we    <= bus.cpu_enable_write;
                        ext_addr  <= bus.cpu_addr;
                        ext_wdata <= bus.cpu_wdata;
                        wait_cnt  <= '0;
                        err_flag  <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.ext_ack) begin
                        ext_req  <= 1'b0;
                        err_flag <= 1'b0;
                        state    <= DONE;
                        if (!ext_we) begin
                            buf_valid <= 1'b1;
                            buf_addr  <= ext_addr;
                            buf_data  <= bus.ext_rdata;
                        end else if (buf_valid && (ext_addr == buf_addr)) begin
                            buf_data <= ext_wdata;
                        end
                    end else if (timeout) begin
                        // Later assignment wins over err_clr above.
                        ext_req   <= 1'b0;
                        buf_valid <= 1'b0;
                        bus_err   <= 1'b1;
                        err_flag  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = (state == DONE) | hit;
    assign bus.cpu_rdata = ((state == DONE) && err_flag) ? 8'hFF : buf_data;
    assign bus.cpu_stall = (bus.cpu_enable_read | bus.cpu_enable_write) & ~bus.cpu_ready;
    assign bus.ext_req   = ext_req;
    assign bus.ext_we    = ext_we;
    assign bus.ext_addr  = ext_addr;
    assign bus.ext_wdata = ext_wdata;
    assign bus.bus_err   = bus_err;

endmodule

// File: tb/tb_misao_mem_ctrl.sv
// Directed scoreboard bench for misao_mem_ctrl: a buffer/error model predicts
// read data and timing, expected data is queued at issue and popped on ready.
module tb_misao_mem_ctrl;

    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    misao_mem_ctrl_if bus();

    misao_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_q[$];
    logic        m_valid = 1'b0;
    logic [14:0] m_addr  = '0;
    logic [7:0]  m_data  = '0;
    logic        m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk("queue_underflow", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.cpu_rdata, e);
        end
    endtask

    task automatic drop_enables;
        bus.cpu_enable_read  = 1'b0;
        bus.cpu_enable_write = 1'b0;
    endtask

    // ack_wait < 0 means the external side never acknowledges.
    task automatic txn(input logic rd, input logic wr, input logic [14:0] a, input logic [7:0] wd,
                       input int ack_wait, input logic [7:0] xd, input logic clr_hold);
        logic       hit;
        logic       got;
        logic [7:0] e;
        int         k;
        int         reqc;
        hit = !wr && rd && m_valid && (m_addr == a);
        if (hit)               e = m_data;
        else if (ack_wait < 0) e = 8'hFF;
        else if (wr)           e = (m_valid && m_addr == a) ? wd : m_data;
        else                   e = xd;
        exp_q.push_back(e);

        @(negedge clk);
        bus.cpu_enable_read  = rd;
        bus.cpu_enable_write = wr;
        bus.cpu_addr         = a;
        bus.cpu_wdata        = wd;
        bus.err_clr          = clr_hold;
        #1;
        if (hit) begin
            chk("hit_ready", bus.cpu_ready, 1);
            chk("hit_stall", bus.cpu_stall, 0);
            pop_cmp("hit_rdata");
            drop_enables();
            bus.err_clr = 1'b0;
            @(negedge clk); #1;
            chk("hit_no_ext_req", bus.ext_req, 0);
            chk("hit_ready_single", bus.cpu_ready, 0);
            return;
        end

        chk("miss_ready_low", bus.cpu_ready, 0);
        chk("miss_stall", bus.cpu_stall, 1);
        k = 0; reqc = 0; got = 1'b0;
        while (!got && k < 60) begin
            @(negedge clk); #1;
            k++;
            if (bus.cpu_ready) begin
                got = 1'b1;
                pop_cmp("done_rdata");
                chk("done_ext_req_low", bus.ext_req, 0);
                if (ack_wait < 0) m_err = 1'b1;
                chk("done_bus_err", bus.bus_err, m_err);
                drop_enables();
                bus.ext_ack = 1'b0;
                bus.err_clr = 1'b0;
            end else if (bus.ext_req) begin
                reqc++;
                if (reqc == 1) begin
                    chk("req_addr", bus.ext_addr, a);
                    chk("req_we", bus.ext_we, wr);
                    if (wr) chk("req_wdata", bus.ext_wdata, wd);
                    // Enable drops mid-transaction; the access must still complete.
                    drop_enables();
                end else begin
                    chk("req_addr_stable", bus.ext_addr, a);
                end
                if (reqc - 1 == ack_wait) begin
                    bus.ext_ack   = 1'b1;
                    bus.ext_rdata = xd;
                end else begin
                    bus.ext_ack   = 1'b0;
                    bus.ext_rdata = ~xd;
                end
            end
        end
        bus.ext_ack = 1'b0;
        chk("ready_seen", got, 1);
        chk("req_cycles", reqc, (ack_wait < 0) ? TO : ack_wait + 1);
        @(negedge clk); #1;
        chk("ready_single_pulse", bus.cpu_ready, 0);

        if (ack_wait < 0)                 m_valid = 1'b0;
        else if (wr) begin
            if (m_valid && m_addr == a)   m_data = wd;
        end else begin
            m_valid = 1'b1; m_addr = a; m_data = xd;
        end
    endtask

    task automatic clear_err;
        repeat (3) @(negedge clk);
        #1 chk("bus_err_sticky", bus.bus_err, 1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1 chk("bus_err_cleared", bus.bus_err, 0);
        m_err = 1'b0;
    endtask

    initial begin
        bus.cpu_enable_read  = 1'b0;
        bus.cpu_enable_write = 1'b0;
        bus.cpu_addr         = '0;
        bus.cpu_wdata        = '0;
        bus.ext_rdata        = '0;
        bus.ext_ack          = 1'b0;
        bus.err_clr          = 1'b0;
        #1;
        chk("rst_ready", bus.cpu_ready, 0);
        chk("rst_ext_req", bus.ext_req, 0);
        chk("rst_ext_we", bus.ext_we, 0);
        chk("rst_ext_addr", bus.ext_addr, 0);
        chk("rst_ext_wdata", bus.ext_wdata, 0);
        chk("rst_bus_err", bus.bus_err, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        txn(1, 0, 15'h0005, 8'h00, 3, 8'h5B, 0);   // read miss
        txn(1, 0, 15'h0005, 8'h00, 0, 8'h00, 0);   // hit
        @(negedge clk);
        bus.ext_ack = 1'b1;                        // stray ack in IDLE
        @(negedge clk); #1;
        chk("idle_ack_no_req", bus.ext_req, 0);
        chk("idle_ack_no_ready", bus.cpu_ready, 0);
        bus.ext_ack = 1'b0;
        txn(1, 0, 15'h0005, 8'h00, 0, 8'h00, 0);   // still hits 5B
        txn(0, 1, 15'h0005, 8'hA3, 1, 8'h00, 0);   // write-through
        txn(1, 0, 15'h0005, 8'h00, 0, 8'h00, 0);   // hit A3
        txn(0, 1, 15'h0006, 8'h77, 0, 8'h00, 0);   // other address
        txn(1, 0, 15'h0005, 8'h00, 0, 8'h00, 0);   // hit A3
        txn(1, 0, 15'h0100, 8'h00, -1, 8'h00, 0);  // timeout
        clear_err();
        txn(1, 0, 15'h0005, 8'h00, 2, 8'h3C, 0);   // buffer was invalidated
        txn(1, 1, 15'h0010, 8'h11, 0, 8'h00, 0);   // write wins
        txn(1, 0, 15'h0200, 8'h00, TO - 1, 8'h9E, 0); // ack on the timeout cycle
        txn(1, 0, 15'h0200, 8'h00, 0, 8'h00, 0);   // hit 9E
        txn(1, 0, 15'h0300, 8'h00, -1, 8'h00, 1);  // set wins over held clear
        clear_err();

        @(negedge clk);
        bus.cpu_enable_read = 1'b1;
        bus.cpu_addr        = 15'h0020;
        @(negedge clk); #1;
        chk("pre_rst_req", bus.ext_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ext_req", bus.ext_req, 0);
        chk("mid_rst_ready", bus.cpu_ready, 0);
        chk("mid_rst_ext_addr", bus.ext_addr, 0);
        chk("mid_rst_rdata", bus.cpu_rdata, 0);
        drop_enables();
        bus.ext_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ack_ignored_req", bus.ext_req, 0);
        chk("post_rst_ack_ignored_ready", bus.cpu_ready, 0);
        bus.ext_ack = 1'b0;
        m_valid = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
        txn(1, 0, 15'h0005, 8'h00, 1, 8'h42, 0);   // must miss after reset

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
